// File: rtl/lut_layer_sequencer.sv
// Serial evaluator for one layer of 6-input LUT neurons.
// Truth tables and fan-in wiring are runtime-loadable. One neuron is evaluated per cycle.
module lut_layer_sequencer #(
  parameter int IN_W      = 64,
  parameter int N_NEURONS = 128,
  parameter int FANIN     = 6,
  parameter int IDX_W     = $clog2(IN_W),
  parameter int NID_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [NID_W-1:0]     cfg_addr,
  input  logic [63:0]          cfg_data,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] out_data,
  output logic                 busy
);

  localparam int TT_W   = 1 << FANIN;
  localparam int CONN_W = FANIN * IDX_W;
  localparam logic [NID_W-1:0] LAST_NID = NID_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                 state_q;
  logic [NID_W-1:0]       cnt_q;
  logic [IN_W-1:0]        in_q;
  logic [N_NEURONS-1:0]   out_data_q;
  logic                   out_valid_q;
  logic                   in_ready_q;
  logic                   cfg_err_q;
  logic                   busy_q;
  logic                   res_vld_q;
  logic                   res_bit_q;
  logic [NID_W-1:0]       res_idx_q;

  logic [TT_W-1:0]        tt_q   [N_NEURONS];
  logic [CONN_W-1:0]      conn_q [N_NEURONS];

  logic                   cfg_ok;
  logic                   hs;
  logic [CONN_W-1:0]      conn_k;
  logic [FANIN-1:0]       lut_addr;
  logic                   lut_bit;

  // Writes land only while idle and in range; anything else is flagged.
  assign cfg_ok = cfg_we && (state_q == IDLE) && (int'(cfg_addr) < N_NEURONS);
  assign hs     = in_valid && in_ready_q;

  // NOTE: storage arrays carry no reset; contents survive rst and a reset
  // would force a flop-based array instead of a plain register file.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      if (cfg_sel) conn_q[cfg_addr] <= cfg_data[CONN_W-1:0];
      else         tt_q[cfg_addr]   <= cfg_data[TT_W-1:0];
    end
  end

  // Fan-in indices beyond the input vector read as zero.
  function automatic logic pick(input logic [IN_W-1:0] vec, input logic [IDX_W-1:0] idx);
    return (int'(idx) < IN_W) ? vec[idx] : 1'b0;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    conn_k   = conn_q[cnt_q];
    lut_addr = '0;
    for (int j = 0; j < FANIN; j++) begin
      lut_addr[j] = pick(in_q, conn_k[j*IDX_W +: IDX_W]);
    end
    lut_bit = tt_q[cnt_q][lut_addr];
  end

  // The looked-up bit is registered and written one cycle later, so the
  // final neuron lands on the same edge that raises out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_vld_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      res_vld_q <= 1'b0;
      if (res_vld_q) out_data_q[res_idx_q] <= res_bit_q;

      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (hs) begin
            in_q       <= in_data;
            out_data_q <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= EVAL;
          end
        end
        EVAL: begin
          res_vld_q <= 1'b1;
          res_bit_q <= lut_bit;
          res_idx_q <= cnt_q;
          if (cnt_q == LAST_NID) state_q <= DONE;
          else                   cnt_q   <= cnt_q + NID_W'(1);
        end
        DONE: begin
          if (res_vld_q) begin
            out_valid_q <= 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_err   = cfg_err_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Randomized bench for lut_layer_sequencer against a truth-table model.
// A second small instance covers out-of-range configuration addresses.
module tb_lut_layer_sequencer;

  localparam int IN_W = 64;
  localparam int N    = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [6:0]    cfg_addr = '0;
  logic [63:0]   cfg_data = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0, in_ready;
  logic [63:0]   in_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [127:0]  out_data;
  logic          busy;

  logic          cfg_we2 = 1'b0;
  logic [6:0]    cfg_addr2 = '0;
  logic          cfg_err2, in_ready2, out_valid2, busy2;
  logic [99:0]   out_data2;

  lut_layer_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  lut_layer_sequencer #(.N_NEURONS(100)) dut_small (
    .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_sel(1'b0), .cfg_addr(cfg_addr2),
    .cfg_data(64'h1), .cfg_err(cfg_err2), .in_valid(1'b0), .in_ready(in_ready2),
    .in_data(64'h0), .out_valid(out_valid2), .out_ready(1'b0), .out_data(out_data2),
    .busy(busy2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int t0       = 0;

  logic [63:0] tt [N];
  int          cn [N][6];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Output bit k is table k indexed by the six selected input bits, slot 0 as LSB.
  function automatic logic [127:0] model(input logic [63:0] din);
    logic [127:0] r;
    int a;
    r = '0;
    for (int k = 0; k < N; k++) begin
      a = 0;
      for (int j = 0; j < 6; j++)
        if (cn[k][j] < IN_W && din[cn[k][j]]) a += (1 << j);
      r[k] = tt[k][a];
    end
    return r;
  endfunction

  function automatic logic [63:0] pack_conn(input int c0, c1, c2, c3, c4, c5);
    logic [63:0] d;
    d = '0;
    d[5:0] = 6'(c0); d[11:6] = 6'(c1); d[17:12] = 6'(c2);
    d[23:18] = 6'(c3); d[29:24] = 6'(c4); d[35:30] = 6'(c5);
    return d;
  endfunction

  function automatic logic [63:0] rand_conn();
    return pack_conn($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
  endfunction

  task automatic model_write(input logic sel, input int addr, input logic [63:0] data);
    if (sel) for (int j = 0; j < 6; j++) cn[addr][j] = int'(data[j*6 +: 6]);
    else     tt[addr] = data;
  endtask

  task automatic cfg_write(input logic sel, input int addr, input logic [63:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 7'(addr); cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_idle", cfg_err, 0);
    model_write(sel, addr, data);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic start_vec(input logic [63:0] din);
    wait_ready();
    in_valid = 1'b1; in_data = din;
    @(negedge clk);
    in_valid = 1'b0;
    t0 = cyc;
    check("busy_eval", busy, 1);
    check("in_ready_eval", in_ready, 0);
  endtask

  logic [127:0] last_out;

  task automatic collect(input logic [127:0] exp, input int hold);
    while (!out_valid && (cyc - t0) < 400) @(negedge clk);
    check("latency", cyc - t0, 129);
    check("out_data", out_data, exp);
    last_out = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, exp);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_valid", out_valid, 0);
    check("rel_in_ready", in_ready, 1);
    check("rel_busy", busy, 0);
  endtask

  task automatic run_vec(input logic [63:0] din, input int hold);
    logic [127:0] exp;
    exp = model(din);
    start_vec(din);
    collect(exp, hold);
  endtask

  initial begin
    logic [63:0]  din;
    logic [127:0] exp;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    for (int k = 0; k < N; k++) begin
      cfg_write(1'b0, k, {$urandom, $urandom});
      cfg_write(1'b1, k, rand_conn());
    end

    // Neuron 0: AND of inputs 0..5.
    cfg_write(1'b1, 0, pack_conn(0, 1, 2, 3, 4, 5));
    cfg_write(1'b0, 0, 64'h8000_0000_0000_0000);
    din = {$urandom, $urandom}; din[5:0] = 6'b111111;
    run_vec(din, 0);
    check("n0_all_ones", last_out[0], 1);
    din[5:0] = 6'b111110;
    run_vec(din, 0);
    check("n0_one_low", last_out[0], 0);

    // Neuron 5: every slot reads input 7.
    cfg_write(1'b1, 5, pack_conn(7, 7, 7, 7, 7, 7));
    cfg_write(1'b0, 5, 64'h2);
    din = {$urandom, $urandom}; din[7] = 1'b1;
    run_vec(din, 0);
    check("n5_addr63", last_out[5], 0);
    din[7] = 1'b0;
    run_vec(din, 0);
    check("n5_addr0_t2", last_out[5], 0);
    cfg_write(1'b0, 5, 64'h1);
    run_vec(din, 0);
    check("n5_addr0_t1", last_out[5], 1);

    // Write attempt mid-evaluation is rejected.
    din = {$urandom, $urandom};
    exp = model(din);
    start_vec(din);
    repeat (5) @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 7'd3; cfg_data = ~tt[3];
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_eval", cfg_err, 1);
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 0);
    collect(exp, 0);

    // Backpressure in DONE with in_valid toggling.
    run_vec({$urandom, $urandom}, 10);

    // Same-edge table write and input handshake.
    wait_ready();
    din = {$urandom, $urandom};
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 7'd0; cfg_data = '1;
    in_valid = 1'b1; in_data = din;
    model_write(1'b0, 0, '1);
    exp = model(din);
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    t0 = cyc;
    check("same_edge_err", cfg_err, 0);
    collect(exp, 0);
    check("same_edge_bit0", last_out[0], 1);

    // Abort with rst at neuron 40, then rerun the same vector.
    din = {$urandom, $urandom};
    run_vec(din, 0);
    start_vec(din);
    while ((cyc - t0) < 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    run_vec(din, 0);

    // Random reconfiguration and vectors.
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 4; w++) begin
        cfg_write(1'b0, $urandom_range(0, N - 1), {$urandom, $urandom});
        cfg_write(1'b1, $urandom_range(0, N - 1), rand_conn());
      end
      run_vec({$urandom, $urandom}, $urandom_range(0, 3));
    end

    // Smaller layer: addresses 100..127 do not exist.
    @(negedge clk);
    cfg_we2 = 1'b1; cfg_addr2 = 7'd120;
    @(negedge clk);
    cfg_we2 = 1'b0;
    check("oob_err", cfg_err2, 1);
    @(negedge clk);
    check("oob_err_pulse", cfg_err2, 0);
    cfg_we2 = 1'b1; cfg_addr2 = 7'd50;
    @(negedge clk);
    cfg_we2 = 1'b0;
    check("inrange_err", cfg_err2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
